mac_stream_engine: RTL and testbench

- Parametrised multiply-accumulate engine that computes sum(a[i]*b[i]) for i = 0..len-1. Operand pairs stream in over a valid/ready handshake, and the result leaves over a valid/ready handshake.
- Control FSM and datapath are integrated in one block.
- The element counter is internal and runtime-programmable; it replaces an external compare signal.
- Supports signed/unsigned operation, optional saturation, sticky overflow and synchronous abort.
- Sits between the operand fetch logic and the result sink.

---
 rtl/mac_stream_engine.sv | 245 ++++++++++++++++++++++++
 tb/tb_mac_stream_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_engine.sv
// ---------------------------------------------------------------------------
// mac_stream_engine
//
// Streaming multiply-accumulate engine. It computes sum(a[i]*b[i]) for
// i = 0..len-1. Operand pairs arrive over a valid/ready handshake and the
// final sum leaves over a second valid/ready handshake. The control FSM,
// the element counter and the two-stage multiply/accumulate pipeline all
// live in this one block.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   go           start request, only looked at in IDLE
//   len          element count, captured when go is taken
//   signed_mode  1 = two's-complement operands, captured when go is taken
//   abort        synchronous cancel, acts in every state except IDLE
//   in_valid     operand pair valid
//   in_ready     engine takes a pair this cycle (high only in LOAD)
//   a, b         operands
//   out_valid    result valid (high only in OUT)
//   out_ready    sink takes the result
//   result       accumulated sum
//   overflow     sticky overflow/saturation flag for the current operation
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the result handshake
//   ps           current state: IDLE=0, LOAD=1, DRAIN=2, OUT=3
// ---------------------------------------------------------------------------
module mac_stream_engine #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24,
   parameter int LEN_W  = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [LEN_W-1:0]  len,
   input  logic              signed_mode,
   input  logic              abort,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  result,
   output logic              overflow,
   output logic              busy,
   output logic              done,
   output logic [1:0]        ps
);

   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t              state;
   logic [LEN_W-1:0]    len_r;
   logic [LEN_W-1:0]    cnt;
   logic                signed_r;
   logic                drain_cnt;

   logic                s1_valid;
   logic [DATA_W-1:0]   s1_a;
   logic [DATA_W-1:0]   s1_b;
   logic                s2_valid;
   logic [PROD_W-1:0]   s2_prod;
   logic [ACC_W-1:0]    acc;

   logic                start;
   logic                kill;
   logic                accept;
   logic [PROD_W-1:0]   op_a_ext;
   logic [PROD_W-1:0]   op_b_ext;
   logic [PROD_W-1:0]   prod;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W:0]      sum;
   logic                add_ovf;
   logic [ACC_W-1:0]    acc_next;

   assign busy = (state != IDLE);
   assign ps   = state;

   // go only counts in IDLE, abort only counts outside IDLE, so the two can
   // never both be active on the same edge. A pair is taken only in LOAD.
   assign start  = (state == IDLE) && go;
   assign kill   = (state != IDLE) && abort;
   assign accept = (state == LOAD) && in_valid && in_ready;

   // Stage-2 product. Extending both operands to the full product width
   // before multiplying means the low PROD_W bits are the correct signed or
   // unsigned product, so one plain multiplier serves both modes.
   always_comb begin
      op_a_ext = {{DATA_W{signed_r & s1_a[DATA_W-1]}}, s1_a};
      op_b_ext = {{DATA_W{signed_r & s1_b[DATA_W-1]}}, s1_b};
      prod     = op_a_ext * op_b_ext;
   end

   // Widen the registered product to accumulator width (sign- or
   // zero-extension), add with a carry bit, and decide overflow. Unsigned
   // overflow is the carry out; signed overflow is two same-sign addends
   // producing a result of the other sign. With saturation the accumulator
   // clamps towards the side it overflowed on, otherwise it wraps.
   always_comb begin
      prod_ext               = '0;
      prod_ext[PROD_W-1:0]   = s2_prod;
      for (int i = PROD_W; i < ACC_W; i++) begin
         prod_ext[i] = signed_r & s2_prod[PROD_W-1];
      end
      sum = {1'b0, acc} + {1'b0, prod_ext};
      if (signed_r) begin
         add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc[ACC_W-1]);
      end else begin
         add_ovf = sum[ACC_W];
      end
      acc_next = acc;
      if (s2_valid) begin
         acc_next = sum[ACC_W-1:0];
         if (SAT_EN && add_ovf) begin
            if (!signed_r) begin
               acc_next = '1;
            end else if (acc[ACC_W-1]) begin
               acc_next = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
               acc_next = {1'b0, {(ACC_W-1){1'b1}}};
            end
         end
      end
   end

   // Control FSM with registered handshake outputs. abort wins over every
   // other transition and suppresses done. The final DRAIN edge is the same
   // edge that folds the last product into the accumulator, so result is
   // loaded from acc_next rather than acc to be final on OUT entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         len_r     <= '0;
         cnt       <= '0;
         signed_r  <= 1'b0;
         drain_cnt <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
      end else begin
         done <= 1'b0;
         if (kill) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (go) begin
                     len_r     <= len;
                     signed_r  <= signed_mode;
                     cnt       <= '0;
                     drain_cnt <= 1'b0;
                     if (len == '0) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        result    <= '0;
                     end else begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                     end
                  end
               end
               LOAD: begin
                  if (accept) begin
                     cnt <= cnt + LEN_W'(1);
                     if (cnt + LEN_W'(1) == len_r) begin
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        drain_cnt <= 1'b0;
                     end
                  end
               end
               DRAIN: begin
                  if (drain_cnt) begin
                     state     <= OUT;
                     out_valid <= 1'b1;
                     result    <= acc_next;
                  end else begin
                     drain_cnt <= 1'b1;
                  end
               end
               OUT: begin
                  if (out_ready) begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     done      <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Multiply/accumulate pipeline. Stage 1 holds the accepted pair, stage 2
   // holds its product, and the accumulator absorbs stage 2 one edge later.
   // Bubbles travel as cleared valid bits. A new go empties the pipe and
   // clears the accumulator and overflow; abort only empties the pipe so the
   // last accumulator/overflow values remain visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s2_valid <= 1'b0;
         s2_prod  <= '0;
         acc      <= '0;
         overflow <= 1'b0;
      end else if (start) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         acc      <= '0;
         overflow <= 1'b0;
      end else if (kill) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_a <= a;
            s1_b <= b;
         end
         s2_valid <= s1_valid;
         s2_prod  <= prod;
         acc      <= acc_next;
         if (s2_valid && add_ovf) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mac_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_mac_stream_engine
//
// Two engines with a 16-bit accumulator run side by side on the same inputs,
// one saturating and one wrapping. Expected sums come from an integer model
// that is updated as each pair is driven and pushed to a scoreboard queue
// when the operation's last pair goes in; entries are popped at the result
// handshake.
// ---------------------------------------------------------------------------
module tb_mac_stream_engine;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int LEN_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              go;
   logic [LEN_W-1:0]  len;
   logic              signed_mode;
   logic              abort;
   logic              in_valid;
   logic              out_ready;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;

   logic              in_ready_s, out_valid_s, overflow_s, busy_s, done_s;
   logic [ACC_W-1:0]  result_s;
   logic [1:0]        ps_s;
   logic              in_ready_w, out_valid_w, overflow_w, busy_w, done_w;
   logic [ACC_W-1:0]  result_w;
   logic [1:0]        ps_w;

   typedef struct {
      logic [15:0] resSat;
      logic        ovfSat;
      logic [15:0] resWrap;
      logic        ovfWrap;
   } expect_t;

   expect_t sb[$];
   int      checks = 0;
   int      errors = 0;
   int      waited;

   longint  mAccSat, mAccWrap;
   bit      mOvfSat, mOvfWrap, mSigned;
   int      mLen, mCount;

   always #5 clk = ~clk;

   mac_stream_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SAT_EN(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .go(go), .len(len), .signed_mode(signed_mode),
      .abort(abort), .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b),
      .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s),
      .overflow(overflow_s), .busy(busy_s), .done(done_s), .ps(ps_s)
   );

   mac_stream_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SAT_EN(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .go(go), .len(len), .signed_mode(signed_mode),
      .abort(abort), .in_valid(in_valid), .in_ready(in_ready_w), .a(a), .b(b),
      .out_valid(out_valid_w), .out_ready(out_ready), .result(result_w),
      .overflow(overflow_w), .busy(busy_w), .done(done_w), .ps(ps_w)
   );

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counted, asserted, reported on failure.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Control outputs of both engines against one expectation.
   task automatic checkControl(input string tag, input logic [1:0] ePs, input logic eInReady,
                               input logic eOutValid, input logic eBusy, input logic eDone);
      checkOutput({tag, ".ps"},         ps_s,        ePs);
      checkOutput({tag, ".in_ready"},   in_ready_s,  eInReady);
      checkOutput({tag, ".out_valid"},  out_valid_s, eOutValid);
      checkOutput({tag, ".busy"},       busy_s,      eBusy);
      checkOutput({tag, ".done"},       done_s,      eDone);
      checkOutput({tag, ".ps_w"},       ps_w,        ePs);
      checkOutput({tag, ".out_valid_w"}, out_valid_w, eOutValid);
      checkOutput({tag, ".done_w"},     done_w,      eDone);
   endtask

   // Integer reference: exact sum, range-checked against the 16-bit limits.
   task automatic modelPair(input logic [7:0] av, input logic [7:0] bv);
      longint p, s, hi, lo;
      if (mSigned) begin
         p  = longint'($signed(av)) * longint'($signed(bv));
         hi = 32767;
         lo = -32768;
      end else begin
         p  = longint'(av) * longint'(bv);
         hi = 65535;
         lo = 0;
      end
      s = mAccSat + p;
      if (s > hi) begin
         s = hi;
         mOvfSat = 1'b1;
      end else if (s < lo) begin
         s = lo;
         mOvfSat = 1'b1;
      end
      mAccSat = s;
      s = mAccWrap + p;
      if (s > hi || s < lo) mOvfWrap = 1'b1;
      s = s & 'hFFFF;
      if (mSigned && s > 32767) s = s - 65536;
      mAccWrap = s;
      mCount++;
      if (mCount == mLen) sb.push_back('{16'(mAccSat), mOvfSat, 16'(mAccWrap), mOvfWrap});
   endtask

   // Issue go (optionally with abort) and reset the model for a new operation.
   task automatic startOp(input int n, input bit sgn, input bit withAbort);
      go          = 1'b1;
      len         = LEN_W'(n);
      signed_mode = sgn;
      abort       = withAbort;
      mAccSat = 0; mAccWrap = 0; mOvfSat = 0; mOvfWrap = 0;
      mSigned = sgn; mLen = n; mCount = 0;
      if (n == 0) sb.push_back('{16'd0, 1'b0, 16'd0, 1'b0});
      tick();
      go    = 1'b0;
      abort = 1'b0;
   endtask

   // Drive one slot: a pair (valid=1) or a bubble (valid=0).
   task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic valid);
      a        = av;
      b        = bv;
      in_valid = valid;
      if (valid) begin
         checkOutput("pair.in_ready", in_ready_s, 1'b1);
         modelPair(av, bv);
      end
      tick();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for out_valid, optionally hold off the sink, then take
   // the result and compare it with the scoreboard head.
   task automatic drainResult(input string tag, input int hold, output int cycles);
      expect_t e;
      cycles    = 0;
      out_ready = (hold == 0);
      while (!out_valid_s && cycles < 20) begin
         tick();
         cycles++;
      end
      checkOutput({tag, ".out_valid_seen"}, out_valid_s, 1'b1);
      for (int i = 0; i < hold; i++) begin
         checkOutput({tag, ".hold_valid"}, out_valid_s, 1'b1);
         if (sb.size() > 0) checkOutput({tag, ".hold_result"}, result_s, sb[0].resSat);
         tick();
      end
      out_ready = 1'b1;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("[TB] FAIL %s.scoreboard: observed=empty expected=entry", tag);
      end else begin
         e = sb.pop_front();
         checkOutput({tag, ".result_sat"},   result_s,   e.resSat);
         checkOutput({tag, ".overflow_sat"}, overflow_s, e.ovfSat);
         checkOutput({tag, ".result_wrap"},  result_w,   e.resWrap);
         checkOutput({tag, ".overflow_wrap"}, overflow_w, e.ovfWrap);
      end
      tick();
      out_ready = 1'b0;
      checkControl({tag, ".done"}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      checkOutput({tag, ".done_clear"}, done_s, 1'b0);
   endtask

   initial begin
      rst = 1'b0; go = 1'b0; len = '0; signed_mode = 1'b0; abort = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #12;
      checkControl("reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset.result",   result_s,   16'd0);
      checkOutput("reset.overflow", overflow_s, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Unsigned len=4 back-to-back; result must appear 3 edges after the
      // last accept (accept edge plus two DRAIN edges).
      startOp(4, 1'b0, 1'b0);
      checkControl("t1.load", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b1;
      applyStimulus(8'd1, 8'd2, 1'b1);
      applyStimulus(8'd3, 8'd4, 1'b1);
      applyStimulus(8'd5, 8'd6, 1'b1);
      applyStimulus(8'd7, 8'd8, 1'b1);
      checkControl("t1.drain", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      drainResult("t1", 0, waited);
      checkOutput("t1.latency", waited, 2);

      // Signed len=3, expected 113; in_ready drops after the third accept.
      startOp(3, 1'b1, 1'b0);
      applyStimulus(8'hFD, 8'd5, 1'b1);
      applyStimulus(8'd127, 8'h80, 1'b1);
      applyStimulus(8'h80, 8'h80, 1'b1);
      checkControl("t2.drain", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      drainResult("t2", 0, waited);

      // Unsigned overflow: saturating engine clamps at 65535, wrapping engine wraps.
      startOp(3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'd255, 8'd255, 1'b1);
      drainResult("t3", 0, waited);

      // Signed negative overflow: clamp to -32768 versus wrap.
      startOp(3, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(8'd127, 8'h80, 1'b1);
      drainResult("t3s", 0, waited);

      // len=0 goes straight to OUT with zero; overflow cleared by the new go.
      startOp(0, 1'b0, 1'b0);
      checkControl("t5.out", 2'd3, 1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("t5.result", result_s, 16'd0);
      drainResult("t5", 0, waited);

      // Bubbles, extra pairs offered in DRAIN, then 5 cycles of backpressure.
      startOp(2, 1'b0, 1'b0);
      applyStimulus(8'd10, 8'd20, 1'b1);
      applyStimulus(8'd0, 8'd0, 1'b0);
      applyStimulus(8'd0, 8'd0, 1'b0);
      applyStimulus(8'd30, 8'd40, 1'b1);
      checkControl("t4.drain", 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
      a = 8'd99; b = 8'd99; in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      drainResult("t4", 5, waited);

      // Abort after one of four pairs: back to IDLE, no done, result kept.
      startOp(4, 1'b0, 1'b0);
      applyStimulus(8'd9, 8'd9, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkControl("abort", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("abort.result_kept", result_s, 16'd1400);
      checkOutput("abort.overflow",    overflow_s, 1'b0);
      tick();
      checkControl("abort.no_done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // go with abort in IDLE: go wins. len=1, (2,3) -> 6.
      startOp(1, 1'b0, 1'b1);
      checkControl("t6.load", 2'd1, 1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'd2, 8'd3, 1'b1);
      drainResult("t6", 0, waited);

      // Asynchronous reset while in DRAIN.
      startOp(1, 1'b0, 1'b0);
      applyStimulus(8'd4, 8'd4, 1'b1);
      checkOutput("t7.in_drain", ps_s, 2'd2);
      sb.delete();
      rst = 1'b0;
      #1;
      checkControl("t7.reset", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("t7.result",   result_s,   16'd0);
      checkOutput("t7.overflow", overflow_s, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      checkOutput("t7.no_done", done_s, 1'b0);

      checkOutput("scoreboard.empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
